// File: rtl/fpu_issuer_pkg.sv
// Shared types and constants for the FPU command issuer and its command FIFO.
// flush_subnormal is used only when FPU_ISSUER_FTZ_EN is defined.
package fpu_issuer_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

   // Widest tag the FIFO entry can carry; narrower tags are zero-extended into it.
   localparam int unsigned MAX_TAG_W = 16;

   typedef struct packed {
      logic [31:0]          a;
      logic [31:0]          b;
      logic [1:0]           op;
      logic [MAX_TAG_W-1:0] tag;
   } cmd_t;

   function automatic logic [31:0] flush_subnormal(input logic [31:0] x);
      if (x[30:23] == 8'h00 && x[22:0] != 23'd0) begin
         return {x[31], 31'd0};
      end
      return x;
   endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO: power-of-two depth, naturally wrapping pointers,
// occupancy count one bit wider than the pointers.
module fpu_cmd_fifo
   import fpu_issuer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  cmd_t push_data,
   input  logic pop,
   output cmd_t head,
   output logic full,
   output logic empty
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

   cmd_t          mem_q [DEPTH];
   cmd_t          mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read when the count says they are valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Host-side initiator for the IEEE754 ALU: queues commands, issues one at a time,
// watches for vld with a timeout. Define FPU_ISSUER_FTZ_EN to flush subnormal operands.
module fpu_cmd_issuer
   import fpu_issuer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned TAG_W          = 4
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [31:0]       cmd_a,
   input  logic [31:0]       cmd_b,
   input  logic [1:0]        cmd_op,
   input  logic [TAG_W-1:0]  cmd_tag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_timeout,
   output logic [31:0]       alu_data1,
   output logic [31:0]       alu_data2,
   output logic [1:0]        alu_opcode,
   output logic              alu_trig,
   input  logic [31:0]       alu_data_out,
   input  logic              alu_vld,
   input  logic              alu_work,
   output logic              busy
);

   localparam int unsigned CW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   cmd_t push_cmd, head_cmd;
   logic fifo_full, fifo_empty, push, pop;
   logic unused_head_bits;

   state_t             state_q, state_d;
   logic               init_q, init_d;
   logic               trig_q, trig_d;
   logic [31:0]        data1_q, data1_d;
   logic [31:0]        data2_q, data2_d;
   logic [1:0]         op_q, op_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_data_q, rsp_data_d;
   logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
   logic               rsp_timeout_q, rsp_timeout_d;

   always_comb begin
      push_cmd.a   = cmd_a;
      push_cmd.b   = cmd_b;
      push_cmd.op  = cmd_op;
      push_cmd.tag = MAX_TAG_W'(cmd_tag);
   end

   assign cmd_ready        = init_q && !fifo_full;
   assign push             = cmd_valid && cmd_ready;
   assign unused_head_bits = ^head_cmd;

   fpu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .push      (push),
      .push_data (push_cmd),
      .pop       (pop),
      .head      (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      init_d        = 1'b1;
      trig_d        = 1'b0;
      data1_d       = '0;
      data2_d       = '0;
      op_d          = '0;
      tag_d         = tag_q;
      cnt_d         = cnt_q;
      cnt_inc       = cnt_q + 1'b1;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_tag_d     = rsp_tag_q;
      rsp_timeout_d = rsp_timeout_q;
      pop           = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty && !alu_work) begin
               pop     = 1'b1;
               trig_d  = 1'b1;
`ifdef FPU_ISSUER_FTZ_EN
               data1_d = flush_subnormal(head_cmd.a);
               data2_d = flush_subnormal(head_cmd.b);
`else
               data1_d = head_cmd.a;
               data2_d = head_cmd.b;
`endif
               op_d    = head_cmd.op;
               tag_d   = head_cmd.tag[TAG_W-1:0];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // vld is checked first so a result arriving in the expiry cycle wins.
            if (alu_vld) begin
               rsp_valid_d   = 1'b1;
               rsp_data_d    = alu_data_out;
               rsp_tag_d     = tag_q;
               rsp_timeout_d = 1'b0;
               state_d       = S_RESP;
            end else if (cnt_inc == CNT_LAST) begin
               rsp_valid_d   = 1'b1;
               rsp_data_d    = TIMEOUT_DATA;
               rsp_tag_d     = tag_q;
               rsp_timeout_d = 1'b1;
               state_d       = S_RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= S_IDLE;
         init_q        <= 1'b0;
         trig_q        <= 1'b0;
         data1_q       <= '0;
         data2_q       <= '0;
         op_q          <= '0;
         tag_q         <= '0;
         cnt_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_tag_q     <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         init_q        <= init_d;
         trig_q        <= trig_d;
         data1_q       <= data1_d;
         data2_q       <= data2_d;
         op_q          <= op_d;
         tag_q         <= tag_d;
         cnt_q         <= cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_tag_q     <= rsp_tag_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign alu_trig    = trig_q;
   assign alu_data1   = data1_q;
   assign alu_data2   = data2_q;
   assign alu_opcode  = op_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_tag     = rsp_tag_q;
   assign rsp_timeout = rsp_timeout_q;
   assign busy        = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Directed self-checking bench for fpu_cmd_issuer with a small ALU response model.
module tb_fpu_cmd_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_a, cmd_b;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_tag;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_tag;
   logic        rsp_timeout;
   logic [31:0] alu_data1, alu_data2;
   logic [1:0]  alu_opcode;
   logic        alu_trig;
   logic [31:0] model_result;
   logic        alu_vld;
   logic        alu_work;
   logic        busy;

   logic        model_en    = 1'b0;
   int          model_delay = 1;
   int          pend        = 0;
   logic        model_vld   = 1'b0;
   logic        inj_vld     = 1'b0;

   int          tests_run    = 0;
   int          tests_failed = 0;

   int          trig_cnt = 0;
   int          rsp_cnt  = 0;
   logic [31:0] trig_a_log [$];
   logic [3:0]  rsp_tag_log [$];

   always #5 clk = ~clk;

   assign alu_vld = model_vld | inj_vld;

   fpu_cmd_issuer #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16),
      .TAG_W          (4)
   ) dut (
      .sys_clk      (clk),
      .sys_rst      (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_op       (cmd_op),
      .cmd_tag      (cmd_tag),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_tag      (rsp_tag),
      .rsp_timeout  (rsp_timeout),
      .alu_data1    (alu_data1),
      .alu_data2    (alu_data2),
      .alu_opcode   (alu_opcode),
      .alu_trig     (alu_trig),
      .alu_data_out (model_result),
      .alu_vld      (alu_vld),
      .alu_work     (alu_work),
      .busy         (busy)
   );

   // ALU model: one-cycle vld pulse a fixed number of cycles after trig is seen.
   always @(posedge clk) begin
      model_vld <= 1'b0;
      if (pend == 1) model_vld <= 1'b1;
      if (pend > 0) pend = pend - 1;
      if (alu_trig && model_en) pend = model_delay;
   end

   always @(posedge clk) begin
      if (alu_trig) begin
         trig_cnt++;
         trig_a_log.push_back(alu_data1);
      end
      if (rsp_valid && rsp_ready) begin
         rsp_cnt++;
         rsp_tag_log.push_back(rsp_tag);
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "bench timeout");
   end

   task automatic push_cmd(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [3:0] tag);
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_tag   = tag;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_trig(output bit found);
      int n = 0;
      while (!alu_trig && n < 20) begin
         @(negedge clk);
         n++;
      end
      found = alu_trig;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({cmd_ready, rsp_valid, rsp_timeout, alu_trig, busy} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b required 00000", {cmd_ready, rsp_valid, rsp_timeout, alu_trig, busy});
      end
      tests_run++;
      if (rsp_data !== 32'h0 || rsp_tag !== 4'h0) begin
         tests_failed++;
         $display("FAIL reset_rsp: got data %h tag %h required 0/0", rsp_data, rsp_tag);
      end
      tests_run++;
      if ({alu_data1, alu_data2, alu_opcode} !== 66'h0) begin
         tests_failed++;
         $display("FAIL reset_alu: got %h %h %h required zeros", alu_data1, alu_data2, alu_opcode);
      end
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: got ready %b busy %b required 1/0", cmd_ready, busy);
      end
   endtask

   task automatic test_single_add();
      int   t0 = trig_cnt;
      int   r0 = rsp_cnt;
      int   n  = 0;
      logic last_vld = 1'b0;
      model_en     = 1'b1;
      model_delay  = 5;
      model_result = 32'h4040_0000;
      push_cmd(32'h3F80_0000, 32'h4000_0000, 2'b00, 4'd5);
      tests_run++;
      if (alu_trig !== 1'b0) begin
         tests_failed++;
         $display("FAIL add_trig_early: got %b required 0", alu_trig);
      end
      @(negedge clk);
      tests_run++;
      if ({alu_trig, alu_data1, alu_data2, alu_opcode} !== {1'b1, 32'h3F80_0000, 32'h4000_0000, 2'b00}) begin
         tests_failed++;
         $display("FAIL add_issue: got trig %b a %h b %h op %b required 1 3f800000 40000000 00",
                  alu_trig, alu_data1, alu_data2, alu_opcode);
      end
      @(negedge clk);
      tests_run++;
      if (alu_trig !== 1'b0 || alu_data1 !== 32'h0 || alu_data2 !== 32'h0) begin
         tests_failed++;
         $display("FAIL add_after_issue: got trig %b a %h b %h required 0 0 0", alu_trig, alu_data1, alu_data2);
      end
      while (!rsp_valid && n < 50) begin
         last_vld = alu_vld;
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (rsp_valid !== 1'b1 || last_vld !== 1'b1) begin
         tests_failed++;
         $display("FAIL add_rsp_latency: got rsp_valid %b prev_vld %b required 1/1", rsp_valid, last_vld);
      end
      tests_run++;
      if (rsp_data !== 32'h4040_0000 || rsp_tag !== 4'd5 || rsp_timeout !== 1'b0) begin
         tests_failed++;
         $display("FAIL add_rsp: got %h tag %0d to %b required 40400000 tag 5 to 0", rsp_data, rsp_tag, rsp_timeout);
      end
      tests_run++;
      if (trig_cnt - t0 !== 1) begin
         tests_failed++;
         $display("FAIL add_trig_count: got %0d required 1", trig_cnt - t0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      tests_run++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_cnt - r0 !== 1) begin
         tests_failed++;
         $display("FAIL add_accept: got valid %b busy %b rsps %0d required 0 0 1", rsp_valid, busy, rsp_cnt - r0);
      end
   endtask

   task automatic test_fifo_full();
      int t0 = trig_cnt;
      int la0, rt0;
      int n = 0;
      alu_work  = 1'b1;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (cmd_ready !== (i < 4)) begin
            tests_failed++;
            $display("FAIL full_ready_%0d: got %b required %b", i, cmd_ready, (i < 4));
         end
         push_cmd(32'h1000_0000 + 32'(i), 32'h2000_0000, 2'(i), 4'(i));
      end
      repeat (5) @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1 || trig_cnt !== t0) begin
         tests_failed++;
         $display("FAIL full_hold: got ready %b busy %b trigs %0d required 0 1 0", cmd_ready, busy, trig_cnt - t0);
      end
      la0          = trig_a_log.size();
      rt0          = rsp_tag_log.size();
      model_en     = 1'b1;
      model_delay  = 2;
      model_result = 32'h1234_5678;
      rsp_ready    = 1'b1;
      alu_work     = 1'b0;
      while (!((rsp_tag_log.size() - rt0 >= 4) && !busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      rsp_ready = 1'b0;
      tests_run++;
      if (trig_cnt - t0 !== 4 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_drain: got trigs %0d busy %b required 4 0", trig_cnt - t0, busy);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (trig_a_log.size() < la0 + 4 || rsp_tag_log.size() < rt0 + 4) begin
            tests_failed++;
            $display("FAIL full_order_%0d: got %0d trigs %0d rsps required 4 each", i,
                     trig_a_log.size() - la0, rsp_tag_log.size() - rt0);
         end else if (trig_a_log[la0+i] !== 32'h1000_0000 + 32'(i) || rsp_tag_log[rt0+i] !== 4'(i)) begin
            tests_failed++;
            $display("FAIL full_order_%0d: got a %h tag %0d required a %h tag %0d", i,
                     trig_a_log[la0+i], rsp_tag_log[rt0+i], 32'h1000_0000 + 32'(i), i);
         end
      end
   endtask

   task automatic test_timeout();
      int r0 = rsp_cnt;
      int n  = 0;
      bit found;
      model_en     = 1'b0;
      model_result = 32'hDEAD_BEEF;
      rsp_ready    = 1'b0;
      push_cmd(32'h0000_0001, 32'h0000_0002, 2'b11, 4'd9);
      wait_trig(found);
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL to_trig: got no trig required one");
      end
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (n !== 16) begin
         tests_failed++;
         $display("FAIL to_latency: got %0d cycles required 16", n);
      end
      tests_run++;
      if (rsp_data !== 32'hFFFF_FFFF || rsp_timeout !== 1'b1 || rsp_tag !== 4'd9) begin
         tests_failed++;
         $display("FAIL to_rsp: got %h to %b tag %0d required ffffffff 1 9", rsp_data, rsp_timeout, rsp_tag);
      end
      inj_vld = 1'b1;
      @(negedge clk);
      inj_vld = 1'b0;
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_timeout !== 1'b1) begin
         tests_failed++;
         $display("FAIL to_late_vld_resp: got v %b %h to %b required 1 ffffffff 1", rsp_valid, rsp_data, rsp_timeout);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      inj_vld   = 1'b1;
      @(negedge clk);
      inj_vld = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_cnt - r0 !== 1) begin
         tests_failed++;
         $display("FAIL to_late_vld_idle: got v %b busy %b rsps %0d required 0 0 1", rsp_valid, busy, rsp_cnt - r0);
      end
   endtask

   task automatic test_vld_at_expiry();
      bit found;
      model_en     = 1'b0;
      model_result = 32'hC0A0_0000;
      rsp_ready    = 1'b0;
      push_cmd(32'h4000_0000, 32'h3F80_0000, 2'b01, 4'd3);
      wait_trig(found);
      repeat (15) @(negedge clk);
      tests_run++;
      if (!found || rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL exp_early: got trig %b rsp_valid %b required 1 0", found, rsp_valid);
      end
      inj_vld = 1'b1;
      @(negedge clk);
      inj_vld = 1'b0;
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_data !== 32'hC0A0_0000 || rsp_tag !== 4'd3) begin
         tests_failed++;
         $display("FAIL exp_vld_wins: got v %b to %b %h tag %0d required 1 0 c0a00000 3",
                  rsp_valid, rsp_timeout, rsp_data, rsp_tag);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int t0 = trig_cnt;
      int n  = 0;
      model_en     = 1'b1;
      model_delay  = 2;
      model_result = 32'h4110_0000;
      rsp_ready    = 1'b0;
      push_cmd(32'h4100_0000, 32'h3F00_0000, 2'b10, 4'd7);
      push_cmd(32'h4200_0000, 32'h3F00_0000, 2'b10, 4'd8);
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         tests_run++;
         if ({rsp_valid, rsp_data, rsp_tag, rsp_timeout} !== {1'b1, 32'h4110_0000, 4'd7, 1'b0}) begin
            tests_failed++;
            $display("FAIL bp_stable_%0d: got v %b %h tag %0d to %b required 1 41100000 7 0",
                     i, rsp_valid, rsp_data, rsp_tag, rsp_timeout);
         end
         tests_run++;
         if (trig_cnt - t0 !== 1) begin
            tests_failed++;
            $display("FAIL bp_no_trig_%0d: got %0d trigs required 1", i, trig_cnt - t0);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      tests_run++;
      if (alu_trig !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_idle_gap: got trig %b required 0", alu_trig);
      end
      @(negedge clk);
      tests_run++;
      if (alu_trig !== 1'b1 || alu_data1 !== 32'h4200_0000) begin
         tests_failed++;
         $display("FAIL bp_second_issue: got trig %b a %h required 1 42000000", alu_trig, alu_data1);
      end
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_tag !== 4'd8) begin
         tests_failed++;
         $display("FAIL bp_second_rsp: got v %b tag %0d required 1 8", rsp_valid, rsp_tag);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_wait();
      int t0 = trig_cnt;
      int r0 = rsp_cnt;
      bit found;
      model_en    = 1'b1;
      model_delay = 8;
      rsp_ready   = 1'b1;
      push_cmd(32'h3F80_0000, 32'h3F80_0000, 2'b00, 4'd2);
      wait_trig(found);
      push_cmd(32'h1, 32'h2, 2'b00, 4'd10);
      push_cmd(32'h3, 32'h4, 2'b00, 4'd11);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      rsp_ready = 1'b0;
      tests_run++;
      if (!found || rsp_cnt !== r0 || rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_wait_rsp: got trig %b rsps %0d valid %b required 1 0 0", found, rsp_cnt - r0, rsp_valid);
      end
      tests_run++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || trig_cnt - t0 !== 1) begin
         tests_failed++;
         $display("FAIL rst_wait_state: got busy %b ready %b trigs %0d required 0 1 1", busy, cmd_ready, trig_cnt - t0);
      end
   endtask

   task automatic test_ftz();
      int          r0 = rsp_cnt;
      int          n  = 0;
      bit          found;
      logic [31:0] exp_a, exp_b;
`ifdef FPU_ISSUER_FTZ_EN
      exp_a = 32'h0000_0000;
      exp_b = 32'h8000_0000;
`else
      exp_a = 32'h0000_0001;
      exp_b = 32'h8040_0000;
`endif
      model_en    = 1'b1;
      model_delay = 3;
      rsp_ready   = 1'b1;
      push_cmd(32'h0000_0001, 32'h8040_0000, 2'b10, 4'd1);
      wait_trig(found);
      tests_run++;
      if (!found || alu_data1 !== exp_a || alu_data2 !== exp_b || alu_opcode !== 2'b10) begin
         tests_failed++;
         $display("FAIL ftz_operands: got %h %h op %b required %h %h 10", alu_data1, alu_data2, alu_opcode, exp_a, exp_b);
      end
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      rsp_ready = 1'b0;
      tests_run++;
      if (rsp_cnt - r0 !== 1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL ftz_complete: got rsps %0d busy %b required 1 0", rsp_cnt - r0, busy);
      end
   endtask

   initial begin
      rst          = 1'b1;
      cmd_valid    = 1'b0;
      cmd_a        = '0;
      cmd_b        = '0;
      cmd_op       = '0;
      cmd_tag      = '0;
      rsp_ready    = 1'b0;
      alu_work     = 1'b0;
      model_result = '0;
      @(negedge clk);
      test_reset();
      test_single_add();
      test_fifo_full();
      test_timeout();
      test_vld_at_expiry();
      test_backpressure();
      test_reset_mid_wait();
      test_ftz();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fpu_cmd_issuer.md
# fpu_cmd_issuer

Host-side initiator for the IEEE754 ALU `Top` block. It accepts floating-point commands over a valid/ready stream and buffers them in a small FIFO. Each command is issued to the ALU as a one-cycle `trig` pulse with its operands. The issuer then waits for `vld`, with a watchdog against an ALU that never responds, and returns the result with its tag over a valid/ready response stream. Only one operation is outstanding at a time.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 1000, maximum WAIT cycles before abort; ≥2
- TAG_W, 4, command tag width
- sys_clk  in  1  single clock, rising edge
- sys_rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_a  in  32  operand 1 (IEEE754 single)
- cmd_b  in  32  operand 2
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
- cmd_tag  in  TAG_W  echoed on response
- rsp_valid  out  1  response held
- rsp_ready  in  1  response accepted
- rsp_data  out  32  ALU result, or 32'hFFFF_FFFF on timeout
- rsp_tag  out  TAG_W  tag of the completed command
- rsp_timeout  out  1  response produced by the watchdog
- alu_data1 / alu_data2  out  32  operands to ALU `data1_in`/`data2_in`
- alu_opcode  out  2  to ALU `opcode`
- alu_trig  out  1  one-cycle start pulse
- alu_data_out  in  32  ALU result
- alu_vld  in  1  ALU result valid
- alu_work  in  1  ALU busy
- busy  out  1  FSM not in IDLE, or FIFO not empty

## Operation
- Push happens when `cmd_valid && cmd_ready`. `cmd_ready = !full`; there is no bypass, so a push while full is rejected even if a pop occurs in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE when the FIFO is not empty and `alu_work == 0`. This transition pops the FIFO head into operand/op/tag registers.
- ISSUE: `alu_trig = 1` for exactly this cycle, with the operands and opcode driven. Then → WAIT.
- WAIT: the watchdog counter increments every cycle.
  - `alu_vld` sampled high: capture `alu_data_out`, set `rsp_timeout = 0`, go → RESP.
  - Counter reaches TIMEOUT_CYCLES−1 without `vld`: set `rsp_data = FFFF_FFFF`, set `rsp_timeout = 1`, go → RESP.
  - `vld` in the expiry cycle wins over the timeout.
- RESP: `rsp_valid = 1`. Data, tag and timeout stay stable until `rsp_ready`. On `rsp_ready`, go → IDLE.
- Outside ISSUE, `alu_data1`, `alu_data2`, `alu_opcode` and `alu_trig` are all 0.
- `alu_vld` outside WAIT is ignored.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The occupancy count is one bit wider.

## Timing
- Reset values:
  - `cmd_ready`, `rsp_valid`, `rsp_data`, `rsp_tag`, `rsp_timeout`, all `alu_*` outputs and `busy` are 0.
  - `cmd_ready` rises the first cycle after `sys_rst` deasserts.
- Reset mid-operation: the FIFO empties, the FSM returns to IDLE, and the in-flight result is dropped (a late `vld` is ignored).
- Latency, with an empty FIFO and idle ALU:
  - Push at edge E → pop at edge E+1 → `alu_trig` high during the cycle after E+1.
  - `vld` sampled at edge V → `rsp_valid` high from V.
- A new `trig` is issued no earlier than the cycle after the response handshake, plus one IDLE cycle.

## Configuration
- FPU_ISSUER_FTZ_EN
  - Defined: a subnormal operand (exp==0, mantissa!=0) has its mantissa zeroed at issue time, keeping the sign. This flushes it to signed zero, since the ALU does not accept subnormals.
  - Undefined: operands are passed to the ALU unchanged.

## Structure
- `fpu_issuer_pkg` holds:
  - state enum
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - TIMEOUT_DATA = 32'hFFFF_FFFF
  - packed command struct {a, b, op, tag}
- Sub-module `fpu_cmd_fifo`: synchronous FIFO of the command struct, with full/empty outputs.

## Test plan
- Single add: push a=3F80_0000 (1.0), b=4000_0000 (2.0), op=00, tag=5. ALU model asserts `vld` 5 cycles after `trig` with 4040_0000. Expect:
  - exactly one `trig` cycle with those operands
  - response 4040_0000, tag 5, `rsp_timeout` 0
- FIFO full: FIFO_DEPTH=4, `alu_work` held high, push 5 commands. Expect:
  - `cmd_ready` drops after the 4th push
  - no `trig` while `alu_work` is high
  - after release, issue order and tags 0..3 are preserved
- Timeout: TIMEOUT_CYCLES=16, ALU never asserts `vld`. Expect `rsp_valid` 16 cycles after `trig`, with data FFFF_FFFF and `rsp_timeout` 1. A late `vld` afterwards is ignored.
- Backpressure: hold `rsp_ready` low for 10 cycles with 2 commands queued. Expect the response stable throughout, and no second `trig` until acceptance.
- Reset mid-WAIT: pulse `sys_rst` for 1 cycle during WAIT, then the ALU asserts `vld`. Expect no response, `busy` 0, and the FIFO empty.
- FTZ: a=0000_0001, b=8040_0000. Expect:
  - with the macro: `alu_data1` = 0000_0000, `alu_data2` = 8000_0000
  - without the macro: both operands unchanged
